// File: rtl/cdm_pkg.sv
// Shared types and helpers for the cell delay meter.
package cdm_pkg;

  // Default build configuration.
  // The result struct below is sized from these values, so a top that
  // overrides NCH or CNT_W must be built against a matching package.
  localparam int unsigned CDM_NCH   = 4;
  localparam int unsigned CDM_CNT_W = 16;

  // Channel-select width.
  // It is wide enough to hold every channel index and also the value nch
  // itself, so an out-of-range request can reach the design and be
  // flagged instead of silently aliasing onto a real channel.
  function automatic int unsigned ch_w(input int unsigned nch);
    return $clog2(nch + 1);
  endfunction

  localparam int unsigned CDM_CH_W = ch_w(CDM_NCH);

  // Measurement sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_FIRE    = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Registered measurement result.
  typedef struct packed {
    logic [CDM_CNT_W-1:0] cnt;
    logic [CDM_CH_W-1:0]  ch;
    logic                 edge_pol;
    logic                 tmo;
    logic                 err;
  } res_t;

endpackage

// File: rtl/sense_sync.sv
// Multi-flop synchroniser for one asynchronous chain output.
module sense_sync
  import cdm_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rn,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain; clear it on reset.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cell_delay_meter.sv
// Propagation-delay meter.
// The meter pre-conditions a chain input, fires an edge into it, and
// counts clk cycles until the synchronised chain output follows.
module cell_delay_meter
  import cdm_pkg::*;
#(
  parameter  int unsigned NCH         = CDM_NCH,
  parameter  int unsigned CNT_W       = CDM_CNT_W,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned SETTLE_CYC  = 8,
  parameter  int unsigned TIMEOUT_CYC = (1 << CNT_W) - 1,
  localparam int unsigned CH_W        = ch_w(NCH)
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             start,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             edge_pol,
  output logic [NCH-1:0]   launch,
  input  logic [NCH-1:0]   sense,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_cnt,
  output logic [CH_W-1:0]  res_ch,
  output logic             res_edge,
  output logic             res_tmo,
  output logic             res_err
);

  localparam logic [CNT_W-1:0] SETTLE_LAST_C = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_C         = CNT_W'(TIMEOUT_CYC);
  localparam logic [CH_W-1:0]  NCH_C         = CH_W'(NCH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             pol_q, pol_d;
  logic [NCH-1:0]   launch_q, launch_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  res_t             res_q, res_d;

  logic [NCH-1:0]   sense_sync_s;
  logic             sel_sense_s;

  for (genvar g = 0; g < NCH; g++) begin : g_sync
    sense_sync #(
      .STAGES (SYNC_STAGES)
    ) u_sense_sync (
      .clk (clk),
      .rn  (rn),
      .d_i (sense[g]),
      .q_o (sense_sync_s[g])
    );
  end

  // Pick the synchronised sense bit of the channel under test.
  always_comb begin
    sel_sense_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_sense_s = sense_sync_s[i];
      end else begin
        sel_sense_s = sel_sense_s;
      end
    end
  end

  // Sequencer next state, shared counter, launch levels and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    pol_d    = pol_q;
    launch_d = launch_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ch_d  = ch_sel;
          pol_d = edge_pol;
          if (ch_sel >= NCH_C) begin
            // Illegal channel: report straight away, launch lines untouched.
            state_d        = ST_DONE;
            res_d.cnt      = '0;
            res_d.ch       = ch_sel;
            res_d.edge_pol = edge_pol;
            res_d.tmo      = 1'b0;
            res_d.err      = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
            for (int i = 0; i < NCH; i++) begin
              if (ch_sel == CH_W'(i)) begin
                launch_d[i] = ~edge_pol;
              end else begin
                launch_d[i] = launch_q[i];
              end
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST_C) begin
          // The edge goes out on entry to FIRE, with the count restarted from zero.
          state_d = ST_FIRE;
          cnt_d   = '0;
          for (int i = 0; i < NCH; i++) begin
            if (ch_q == CH_W'(i)) begin
              launch_d[i] = pol_q;
            end else begin
              launch_d[i] = launch_q[i];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIRE: begin
        state_d = ST_MEASURE;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_MEASURE: begin
        if (sel_sense_s == pol_q) begin
          state_d        = ST_DONE;
          res_d.cnt      = cnt_q;
          res_d.ch       = ch_q;
          res_d.edge_pol = pol_q;
          res_d.tmo      = 1'b0;
          res_d.err      = 1'b0;
        end else if (cnt_q >= TMO_C) begin
          state_d        = ST_DONE;
          res_d.cnt      = TMO_C;
          res_d.ch       = ch_q;
          res_d.edge_pol = pol_q;
          res_d.tmo      = 1'b1;
          res_d.err      = 1'b0;
        end else begin
          // Stops at the timeout, so it can never wrap.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (res_valid_q && res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags.
  // res_valid rises on the cycle after DONE is entered and falls with the
  // accepting handshake.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_q == ST_DONE) && !(res_valid_q && res_ready);
  end

  // State, counter, launch and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ch_q        <= '0;
      pol_q       <= 1'b0;
      launch_q    <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      pol_q       <= pol_d;
      launch_q    <= launch_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign launch    = launch_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_cnt   = res_q.cnt;
  assign res_ch    = res_q.ch;
  assign res_edge  = res_q.edge_pol;
  assign res_tmo   = res_q.tmo;
  assign res_err   = res_q.err;

endmodule

// File: tb/tb_cell_delay_meter.sv
// Self-checking bench for cell_delay_meter.
// Each test chain is modelled as a pure N-cycle delay line.
module tb_cell_delay_meter;

  localparam int NCH    = 4;
  localparam int CNT_W  = 16;
  localparam int SS     = 2;
  localparam int SETTLE = 8;
  localparam int TMO    = 100;
  localparam int CH_W   = 3;

  logic             clk;
  logic             rn;
  logic             start;
  logic [CH_W-1:0]  ch_sel;
  logic             edge_pol;
  logic [NCH-1:0]   launch;
  logic [NCH-1:0]   sense;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_cnt;
  logic [CH_W-1:0]  res_ch;
  logic             res_edge;
  logic             res_tmo;
  logic             res_err;

  int tests = 0;
  int fails = 0;

  // Chain model state.
  int unsigned dly   [NCH] = '{1, 1, 1, 1};
  bit          stuck [NCH] = '{0, 0, 0, 0};
  logic [31:0] hist  [NCH];

  // Expected launch levels.
  logic [NCH-1:0] mlaunch;

  cell_delay_meter #(
    .NCH         (NCH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SS),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rn        (rn),
    .start     (start),
    .ch_sel    (ch_sel),
    .edge_pol  (edge_pol),
    .launch    (launch),
    .sense     (sense),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_cnt   (res_cnt),
    .res_ch    (res_ch),
    .res_edge  (res_edge),
    .res_tmo   (res_tmo),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delay lines: each chain output trails its launch bit by dly cycles.
  always @(posedge clk or negedge rn) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rn) hist[i] <= 32'd0;
      else     hist[i] <= {hist[i][30:0], launch[i]};
    end
  end

  // Chain outputs, optionally stuck low.
  always_comb begin
    sense = '0;
    for (int i = 0; i < NCH; i++) begin
      sense[i] = stuck[i] ? 1'b0 : hist[i][dly[i]-1];
    end
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string tag, input logic [15:0] ecnt, input logic [2:0] ech,
                           input logic epol, input logic etmo, input logic eerr);
    check({tag, "_cnt"}, 32'(res_cnt), 32'(ecnt));
    check({tag, "_ch"},  32'(res_ch),  32'(ech));
    check({tag, "_edge"}, 32'(res_edge), 32'(epol));
    check({tag, "_tmo"}, 32'(res_tmo), 32'(etmo));
    check({tag, "_err"}, 32'(res_err), 32'(eerr));
  endtask

  // One full measurement with reference-model expectations.
  task automatic run(input logic [2:0] ch, input logic pol, input int rdy_wait, input bit poke);
    logic [15:0]    ecnt;
    logic           etmo;
    logic           eerr;
    logic [NCH-1:0] exp_l;
    bit             legal;
    int             n;
    legal = (ch < 3'd4);
    if (!legal) begin
      ecnt = 16'd0; etmo = 1'b0; eerr = 1'b1;
    end else if (stuck[ch[1:0]]) begin
      ecnt = 16'(TMO); etmo = 1'b1; eerr = 1'b0;
    end else begin
      ecnt = 16'(dly[ch[1:0]] + SS); etmo = 1'b0; eerr = 1'b0;
    end

    start = 1'b1; ch_sel = ch; edge_pol = pol;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    if (legal) begin
      exp_l = mlaunch;
      exp_l[ch[1:0]] = ~pol;
      for (int k = 0; k < SETTLE; k++) begin
        check("settle_launch", 32'(launch), 32'(exp_l));
        tick();
      end
      exp_l[ch[1:0]] = pol;
      check("fire_launch", 32'(launch), 32'(exp_l));
      mlaunch = exp_l;
    end else begin
      check("err_launch", 32'(launch), 32'(mlaunch));
      check("err_valid_lat1", 32'(res_valid), 32'd0);
      tick();
      check("err_valid_lat2", 32'(res_valid), 32'd1);
    end

    n = 0;
    while (!res_valid && n < TMO + 40) begin
      tick();
      n++;
    end
    check("valid_seen", 32'(res_valid), 32'd1);
    for (int k = 0; k < rdy_wait; k++) begin
      if (poke) begin
        start = 1'b1; ch_sel = 3'($urandom_range(0, 3)); edge_pol = 1'($urandom_range(0, 1));
      end
      check_res("hold", ecnt, ch, pol, etmo, eerr);
      check("hold_valid", 32'(res_valid), 32'd1);
      tick();
    end
    check_res("res", ecnt, ch, pol, etmo, eerr);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    check("valid_drop", 32'(res_valid), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("launch_idle", 32'(launch), 32'(mlaunch));
    tick();
    check("still_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rn = 1'b0; start = 1'b0; ch_sel = 3'd0; edge_pol = 1'b0; res_ready = 1'b0;
    mlaunch = '0;
    #1;
    check("rst_launch", 32'(launch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check_res("rst", 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rn = 1'b1;
    tick();

    // Delay 5 on ch2, rising edge.
    dly[2] = 5;
    run(3'd2, 1'b1, 0, 1'b0);

    // Stuck-low chain times out.
    stuck[3] = 1'b1;
    run(3'd3, 1'b1, 1, 1'b0);
    stuck[3] = 1'b0;

    // Illegal channel.
    run(3'd5, 1'b1, 0, 1'b0);

    // Result held 20 cycles while extra starts are ignored.
    dly[1] = 4;
    run(3'd1, 1'b0, 20, 1'b1);

    // Reset during MEASURE.
    dly[1] = 5;
    start = 1'b1; ch_sel = 3'd1; edge_pol = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    #2 rn = 1'b0;
    #1;
    check("mid_rst_launch", 32'(launch), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    mlaunch = '0;
    @(negedge clk) rn = 1'b1;
    tick();
    run(3'd1, 1'b1, 0, 1'b0);

    // Back-to-back opposite edges on ch0.
    dly[0] = 3;
    run(3'd0, 1'b1, 1, 1'b0);
    run(3'd0, 1'b0, 0, 1'b0);

    // Randomised runs.
    for (int r = 0; r < 12; r++) begin
      logic [2:0] c;
      c = 3'($urandom_range(0, 5));
      if (c < 3'd4) dly[c[1:0]] = $urandom_range(1, 7);
      run(c, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
